ttl74x259_seq: RTL
==================

TTL74X259_SEQ -- requirements
Module: ttl74x259_seq

Interface
REQ-001 Parameter WIDTH, default 8, sets the number of latched outputs; legal values are powers of two, 2..64.
REQ-002 Localparam SEL_WIDTH = $clog2(WIDTH), the address width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 A  input  SEL_WIDTH  direct-mode latch address.
REQ-006 D  input  1  direct-mode data bit.
REQ-007 G_n  input  1  direct-mode enable, active LOW.
REQ-008 CLR_n  input  1  direct-mode clear, active LOW.
REQ-009 start  input  1  one-cycle pulse that launches a serial load.
REQ-010 s_valid  input  1  serial bit valid.
REQ-011 s_data  input  1  serial data bit.
REQ-012 s_ready  output  1  sequencer accepts a serial bit this cycle.
REQ-013 busy  output  1  sequencer is not IDLE.
REQ-014 done  output  1  one-cycle pulse marking serial load completion.
REQ-015 Q  output  WIDTH  registered latch outputs; Q[i] is the bit at address i.

Function
REQ-016 The direct modes are evaluated at each clk edge only while the sequencer is IDLE:
- Addressable latch: G_n=0 and CLR_n=1 give Q[A]<=D; other bits hold.
- Memory: G_n=1 and CLR_n=1 make all Q bits hold.
- Demux: G_n=0 and CLR_n=0 give Q[A]<=D; all other bits <=0.
- Clear: G_n=1 and CLR_n=0 make all Q bits <=0.
REQ-017 The sequencer states are IDLE, LOAD and DONE.
REQ-018 IDLE -> LOAD on start=1; the bit counter is set to 0 on that edge, and the direct mode is still applied on that edge.
REQ-019 In LOAD, s_ready=1 and busy=1; the direct inputs A, D, G_n and CLR_n are ignored.
REQ-020 In LOAD, s_valid=1 is a beat: Q[cnt]<=s_data and cnt<=cnt+1.
REQ-021 In LOAD, cycles with s_valid=0 change nothing.
REQ-022 On the beat with cnt=WIDTH-1, the state goes LOAD -> DONE; cnt wraps to 0.
REQ-023 DONE lasts exactly one cycle with done=1, busy=1 and s_ready=0; it then returns to IDLE.
REQ-024 Bit order is LSB-first: the first accepted bit lands in Q[0].
REQ-025 start is ignored in LOAD and DONE.
REQ-026 start is accepted again in the first IDLE cycle after DONE.
REQ-027 Bits of Q not yet written during LOAD keep their value from before start.
REQ-028 Latency: a bit accepted at edge k is visible on Q after edge k.
REQ-029 done rises on the edge after the final beat.
REQ-030 s_ready, busy and done are decoded from registered state only, with no combinational path from inputs.

Reset
REQ-031 When rst=1 at a clk edge: Q<=0, state<=IDLE, cnt<=0; s_ready, busy and done are then 0.
REQ-032 rst has priority over every mode, start and beat.
REQ-033 rst during LOAD or DONE aborts the load with no done pulse.

Structure
REQ-034 The shared package ttl_pkg holds:
- the sequencer state enum (IDLE, LOAD, DONE);
- the 2-bit direct-mode encoding {CLR_n, G_n}.
REQ-035 The sub-module ttl74x259_core holds the WIDTH-bit register bank and its write/clear logic; its inputs are a write address, a data bit, a write enable and a clear-others enable.
REQ-036 The top level contains only:
- the sequencer;
- the bit counter;
- steering of the core inputs between direct and serial sources.

Verification
REQ-037 Latch/memory: with WIDTH=8, from reset, write D=1 at A=3, then A=6 with G_n=0 and CLR_n=1; then hold G_n=1 for 5 cycles -> Q=8'h48 throughout.
REQ-038 Demux and clear:
- From Q=8'hFF, apply G_n=0, CLR_n=0, A=2, D=1 -> Q=8'h04.
- Then apply G_n=1, CLR_n=0 -> Q=8'h00.
REQ-039 Serial load: pulse start, then drive 8 beats LSB-first of 8'hA5 with s_valid low on beats 3 and 6 -> Q=8'hA5 and done=1 for exactly one cycle one edge after the last beat; busy is high from start+1 through DONE.
REQ-040 Ignored inputs: during LOAD, drive CLR_n=0, G_n=1 and another start pulse -> no clear and no restart; the final Q equals the serial data.
REQ-041 Reset mid-load: assert rst after 4 of 8 beats -> the next cycle shows Q=0, busy=0, done=0, s_ready=0; a new start then loads correctly from Q[0].

Source files
------------

// File: rtl/ttl_pkg.sv
// Shared types for the 74x259-style addressable latch with serial loader:
// sequencer states and the {CLR_n, G_n} direct-mode encoding.
package ttl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    DONE = 2'b10
  } seq_state_e;

  // Index is {CLR_n, G_n}; both controls are active low.
  typedef enum logic [1:0] {
    MODE_DEMUX  = 2'b00,
    MODE_CLEAR  = 2'b01,
    MODE_LATCH  = 2'b10,
    MODE_MEMORY = 2'b11
  } mode_e;

endpackage

// File: rtl/ttl74x259_core.sv
// WIDTH-bit latch bank: optional clear of all bits, then optional single-bit
// write. Clear plus write gives the demux behaviour.
module ttl74x259_core
  import ttl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SEL_WIDTH = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEL_WIDTH-1:0] wr_addr,
  input  logic                 wr_data,
  input  logic                 wr_en,
  input  logic                 clr_others,
  output logic [WIDTH-1:0]     q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next bank value: clear first so a simultaneous write survives.
  always_comb begin
    q_d = q_q;
    if (clr_others) begin
      q_d = {WIDTH{1'b0}};
    end else begin
      q_d = q_q;
    end
    if (wr_en) begin
      q_d[wr_addr] = wr_data;
    end else begin
      q_d[wr_addr] = q_d[wr_addr];
    end
  end

  // Bank register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= {WIDTH{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ttl74x259_seq.sv
// Addressable latch with a direct (74x259) port and an LSB-first serial
// loader; the top holds the sequencer, bit counter and core-input steering.
module ttl74x259_seq
  import ttl_pkg::*;
#(
  parameter int WIDTH     = 8,
  localparam int SEL_WIDTH = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEL_WIDTH-1:0] A,
  input  logic                 D,
  input  logic                 G_n,
  input  logic                 CLR_n,
  input  logic                 start,
  input  logic                 s_valid,
  input  logic                 s_data,
  output logic                 s_ready,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     Q
);

  localparam logic [SEL_WIDTH-1:0] CNT_LAST = SEL_WIDTH'(WIDTH - 1);
  localparam logic [SEL_WIDTH-1:0] CNT_ONE  = SEL_WIDTH'(1);

  seq_state_e           state_q, state_d;
  logic [SEL_WIDTH-1:0] cnt_q, cnt_d;
  logic                 s_ready_q, s_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [SEL_WIDTH-1:0] core_addr_s;
  logic                 core_data_s;
  logic                 core_wr_s;
  logic                 core_clr_s;
  mode_e                mode_s;

  assign mode_s = mode_e'({CLR_n, G_n});

  // Sequencer next state, bit counter, and core-input steering.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    core_addr_s = A;
    core_data_s = D;
    core_wr_s   = 1'b0;
    core_clr_s  = 1'b0;
    case (state_q)
      IDLE: begin
        case (mode_s)
          MODE_LATCH:  core_wr_s = 1'b1;
          MODE_DEMUX: begin
            core_wr_s  = 1'b1;
            core_clr_s = 1'b1;
          end
          MODE_CLEAR:  core_clr_s = 1'b1;
          MODE_MEMORY: core_wr_s = 1'b0;
          default:     core_wr_s = 1'b0;
        endcase
        if (start) begin
          state_d = LOAD;
          cnt_d   = {SEL_WIDTH{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        core_addr_s = cnt_q;
        core_data_s = s_data;
        core_wr_s   = s_valid;
        if (s_valid) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags are flopped from the next state so they carry no input path.
  always_comb begin
    s_ready_d = (state_d == LOAD);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  // Sequencer, counter and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= {SEL_WIDTH{1'b0}};
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  ttl74x259_core #(
    .WIDTH     (WIDTH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .wr_addr    (core_addr_s),
    .wr_data    (core_data_s),
    .wr_en      (core_wr_s),
    .clr_others (core_clr_s),
    .q          (Q)
  );

  assign s_ready = s_ready_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
